// File: rtl/cache_pkg.sv
// Shared types and lane helpers for the direct-mapped data cache.
// Size encodings, FSM states and byte-lane strobe/extract functions.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE,
    RESP
  } dc_state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10
  } acc_size_e;

  function automatic logic [3:0] size_to_strb(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] s;
    case (size)
      SZ_BYTE: s = 4'b0001 << off;
      SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_extract(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  off
  );
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_BYTE: r = {24'h0, sh[7:0]};
      SZ_HALF: r = off[1] ? {16'h0, word[31:16]}
                          : {16'h0, word[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_replicate(
    input logic [31:0] data,
    input logic [1:0]  size
  );
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{data[7:0]}};
      SZ_HALF: r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays: whole-line refill port, byte-strobed word port,
// combinational read of one set.
module dcache_line_store #(
  parameter int IDX_BITS = 4,
  parameter int OFF_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [IDX_BITS-1:0]            rd_set,
  input  logic [OFF_BITS-1:0]            rd_off,
  output logic                           rd_valid,
  output logic [TAG_BITS-1:0]            rd_tag,
  output logic [31:0]                    rd_word,
  input  logic [IDX_BITS-1:0]            wr_set,
  input  logic                           line_we,
  input  logic [TAG_BITS-1:0]            line_tag,
  input  logic [(2**OFF_BITS)*32-1:0]    line_data,
  input  logic                           word_we,
  input  logic [OFF_BITS-1:0]            word_off,
  input  logic [3:0]                     word_strb,
  input  logic [31:0]                    word_data
);

  localparam int SETS  = 2**IDX_BITS;
  localparam int WORDS = 2**OFF_BITS;

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [31:0]         data_q [SETS][WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n)
      valid_q <= '0;
    else if (line_we)
      valid_q[wr_set] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[wr_set] <= line_tag;
      for (int w = 0; w < WORDS; w++)
        data_q[wr_set][w] <= line_data[w*32 +: 32];
    end else if (word_we) begin
      for (int b = 0; b < 4; b++)
        if (word_strb[b])
          data_q[wr_set][word_off][b*8 +: 8] <= word_data[b*8 +: 8];
    end
  end

  assign rd_valid = valid_q[rd_set];
  assign rd_tag   = tag_q[rd_set];
  assign rd_word  = data_q[rd_set][rd_off];

endmodule

// File: rtl/dcache_dm_refill.sv
// Direct-mapped write-through data cache with sequential line refill.
// Optional hit/miss counters when DCACHE_STATS_EN is defined.
module dcache_dm_refill
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_BITS   = 4,
  parameter int OFF_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);

  localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - OFF_BITS - 2;
  localparam int WORDS    = 2**OFF_BITS;

  dc_state_e state_q, state_d;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic [31:0]           r_wdata;
  logic [OFF_BITS-1:0]   cnt_q;
  logic                  pend_q;
  logic [WORDS-1:0][31:0] buf_q;
  logic [WORDS-1:0][31:0] fill;

  logic [OFF_BITS-1:0] r_off;
  logic [IDX_BITS-1:0] r_set;
  logic [TAG_BITS-1:0] r_tag;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0]         rd_word;
  logic                hit;
  logic                line_we;
  logic                word_we;

  assign r_off = r_addr[OFF_BITS+1:2];
  assign r_set = r_addr[IDX_BITS+OFF_BITS+1:OFF_BITS+2];
  assign r_tag = r_addr[ADDR_WIDTH-1:IDX_BITS+OFF_BITS+2];
  assign hit   = rd_valid && (rd_tag == r_tag);

  // Last refill word bypasses the buffer so the line lands in one write.
  always_comb begin
    fill        = buf_q;
    fill[cnt_q] = mem_rdata;
  end

  dcache_line_store #(
    .IDX_BITS (IDX_BITS),
    .OFF_BITS (OFF_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_set    (r_set),
    .rd_off    (r_off),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .wr_set    (r_set),
    .line_we   (line_we),
    .line_tag  (r_tag),
    .line_data (fill),
    .word_we   (word_we),
    .word_off  (r_off),
    .word_strb (size_to_strb(r_size, r_addr[1:0])),
    .word_data (lane_replicate(r_wdata, r_size))
  );

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    rsp_rdata     = '0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    mem_wdata     = '0;
    mem_wstrb     = '0;
    line_we       = 1'b0;
    word_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = req_we ? WRITE : RESP;
      end
      RESP: begin
        // Loads arrive here straight from IDLE; a miss diverts to REFILL.
        if (r_we || hit) begin
          rsp_valid = 1'b1;
          if (!r_we)
            rsp_rdata = lane_extract(rd_word, r_size, r_addr[1:0]);
          state_d = IDLE;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req_valid = !pend_q;
        mem_addr      = {r_tag, r_set, cnt_q, 2'b00};
        if (pend_q && mem_rsp_valid && (&cnt_q)) begin
          line_we = 1'b1;
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_wdata     = lane_replicate(r_wdata, r_size);
        mem_wstrb     = size_to_strb(r_size, r_addr[1:0]);
        if (mem_req_ready) begin
          word_we = hit;
          state_d = RESP;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (req_valid && req_ready) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_size  <= req_size;
        r_wdata <= req_wdata;
      end
      if (state_q == REFILL) begin
        if (mem_req_valid && mem_req_ready)
          pend_q <= 1'b1;
        if (pend_q && mem_rsp_valid) begin
          pend_q <= 1'b0;
          cnt_q  <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == REFILL && pend_q && mem_rsp_valid)
      buf_q[cnt_q] <= mem_rdata;
  end

`ifdef DCACHE_STATS_EN
  // A refilled load revisits RESP as a hit; it was already counted as a miss.
  logic refilled_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refilled_q  <= 1'b0;
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (req_valid && req_ready)
        refilled_q <= 1'b0;
      else if (line_we)
        refilled_q <= 1'b1;
      if (state_q == RESP && !r_we && !refilled_q) begin
        if (hit) begin
          if (~&stat_hits)
            stat_hits <= stat_hits + 32'd1;
        end else begin
          if (~&stat_misses)
            stat_misses <= stat_misses + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm_refill.sv
// Scoreboard bench for dcache_dm_refill: directed scenarios then random
// traffic against a flat-memory reference with a tag-only hit predictor.
module tb_dcache_dm_refill;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  dcache_dm_refill dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_size      (req_size),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits     (stat_hits),
    .stat_misses   (stat_misses)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic [31:0] ram     [0:16383];
  logic [31:0] ref_mem [0:16383];
  bit          mv [16];
  logic [7:0]  mt [16];

  typedef struct { logic [15:0] a; logic [3:0] s; logic [31:0] d; } wr_t;
  typedef struct { bit c; logic [31:0] d; } rsp_t;

  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];
  rsp_t        exp_rsp[$];

  int unsigned rd_count = 0, wr_count = 0, rsp_count = 0;
  bit          stray_en = 0;
  logic [31:0] last_rdata, last_wdata;
  logic [3:0]  last_wstrb;

  function automatic logic [31:0] ref_ext(input logic [1:0] sz,
      input logic [15:0] a, input logic [31:0] w);
    case (sz)
      2'b01:   return (w >> (8 * a[1:0])) & 32'hFF;
      2'b10:   return (w >> (16 * a[1])) & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [1:0] sz,
      input logic [15:0] a);
    case (sz)
      2'b01:   return 4'b0001 << a[1:0];
      2'b10:   return 4'b0011 << (2 * a[1]);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] ref_rep(input logic [1:0] sz,
      input logic [31:0] w);
    case (sz)
      2'b01:   return w[7:0] * 32'h01010101;
      2'b10:   return w[15:0] * 32'h00010001;
      default: return w;
    endcase
  endfunction

  // Memory responder: random ready, 1..3 cycle read latency, stray pulses.
  initial begin
    bit          pend;
    int          dly;
    logic [13:0] pa;
    wr_t         e;
    pend = 0; dly = 0; pa = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; mem_rsp_valid = 0; mem_req_ready = 0;
        continue;
      end
      mem_rsp_valid = 0;
      if (pend) begin
        if (dly == 0) begin
          mem_rsp_valid = 1; mem_rdata = ram[pa];
          pend = 0; rsp_count++;
        end else dly--;
      end else if (stray_en && $urandom_range(7) == 0) begin
        mem_rsp_valid = 1; mem_rdata = $urandom;
      end
      mem_req_ready = ($urandom_range(3) != 0);
      if (mem_req_valid && mem_req_ready) begin
        if (mem_we) begin
          wr_count++;
          last_wstrb = mem_wstrb; last_wdata = mem_wdata;
          chk("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            chk("wr_addr", mem_addr, e.a);
            chk("wr_strb", mem_wstrb, e.s);
            chk("wr_data", mem_wdata, e.d);
          end
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) ram[mem_addr[15:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
        end else begin
          rd_count++;
          chk("rd_one_outstanding", pend, 0);
          chk("rd_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0) chk("rd_addr", mem_addr, exp_rd.pop_front());
          pend = 1; pa = mem_addr[15:2]; dly = $urandom_range(2);
        end
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        last_rdata = rsp_rdata;
        chk("rsp_expected", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) begin
          e = exp_rsp.pop_front();
          if (e.c) chk("rsp_rdata", rsp_rdata, e.d);
        end
      end
    end
  end

  task automatic reset_checks();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
  endtask

  task automatic drive(input bit we, input logic [15:0] a,
      input logic [1:0] sz, input logic [31:0] wd);
    @(negedge clk);
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    req_valid = 1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic txn(input bit we, input logic [15:0] a,
      input logic [1:0] sz, input logic [31:0] wd);
    int unsigned rd0, wr0;
    bit          hit, got;
    int          n;
    logic [3:0]  st;
    logic [31:0] rp;
    rsp_t        r;
    hit = mv[a[7:4]] && (mt[a[7:4]] == a[15:8]);
    rd0 = rd_count; wr0 = wr_count;
    if (we) begin
      st = ref_strb(sz, a); rp = ref_rep(sz, wd);
      for (int b = 0; b < 4; b++)
        if (st[b]) ref_mem[a[15:2]][b*8 +: 8] = rp[b*8 +: 8];
      exp_wr.push_back('{a: {a[15:2], 2'b00}, s: st, d: rp});
      r.c = 0; r.d = '0;
    end else begin
      if (!hit) begin
        for (int w = 0; w < 4; w++)
          exp_rd.push_back({a[15:4], w[1:0], 2'b00});
        mv[a[7:4]] = 1; mt[a[7:4]] = a[15:8];
      end
      r.c = 1; r.d = ref_ext(sz, a, ref_mem[a[15:2]]);
    end
    exp_rsp.push_back(r);
    drive(we, a, sz, wd);
    got = 0; n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); n++;
      if (rsp_valid) begin got = 1; break; end
    end
    chk("rsp_arrived", got, 1);
    if (got) begin
      if (!we && hit) chk("hit_latency", n, 1);
      chk("mem_reads", rd_count - rd0, (we || hit) ? 0 : 4);
      chk("mem_writes", wr_count - wr0, we ? 1 : 0);
      @(negedge clk);
      chk("rsp_one_cycle", rsp_valid, 0);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 16; s++) mv[s] = 0;
    exp_rd.delete(); exp_wr.delete(); exp_rsp.delete();
  endtask

  initial begin
    logic [7:0] tags [4];
    int unsigned rsp0;
    bit          ok;
    logic [15:0] a;
    tags[0] = 8'h00; tags[1] = 8'h01; tags[2] = 8'h5A; tags[3] = 8'hFF;
    for (int i = 0; i < 16384; i++) ram[i] = i * 32'h9E3779B1 + 32'h01234567;
    ram[4] = 32'h11223344; ram[5] = 32'h55667788;
    ram[6] = 32'h99AABBCC; ram[7] = 32'hDDEEFF00;
    for (int i = 0; i < 16384; i++) ref_mem[i] = ram[i];
    model_clear();
    req_valid = 0; req_we = 0; req_addr = '0; req_size = '0; req_wdata = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_checks();
    @(negedge clk) rst_n = 1;

    txn(0, 16'h0010, 2'b00, 0);
    chk("t1_data", last_rdata, 32'h11223344);
    txn(0, 16'h0014, 2'b00, 0);
    chk("t2_data", last_rdata, 32'h55667788);
    txn(1, 16'h0015, 2'b01, 32'h000000AB);
    chk("t3_wstrb", last_wstrb, 4'b0010);
    chk("t3_wdata", last_wdata, 32'hABABABAB);
    txn(0, 16'h0014, 2'b00, 0);
    chk("t3_merged", last_rdata, 32'h5566AB88);
    txn(0, 16'h0110, 2'b00, 0);
    txn(0, 16'h0010, 2'b00, 0);
    txn(0, 16'h0016, 2'b10, 0);
    chk("t5_half", last_rdata, 32'h00005566);
    txn(0, 16'h0017, 2'b01, 0);
    chk("t5_byte", last_rdata, 32'h00000055);

    // Reset while the third word of a refill is in flight.
    exp_rd.delete();
    for (int w = 0; w < 4; w++) exp_rd.push_back({12'h020, w[1:0], 2'b00});
    rsp0 = rsp_count;
    drive(0, 16'h0200, 2'b00, 0);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_count - rsp0 >= 2) begin ok = 1; break; end
    end
    chk("t6_word2_reached", ok, 1);
    @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 chk("t6_mem_req_drop", mem_req_valid, 0);
    chk("t6_no_rsp", rsp_valid, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset_checks();
    @(negedge clk) rst_n = 1;
    txn(0, 16'h0200, 2'b00, 0);

    stray_en = 1;
    for (int k = 0; k < 400; k++) begin
      a = {tags[$urandom_range(3)], 4'($urandom_range(15)), 4'($urandom)};
      txn($urandom_range(9) < 3, a, 2'($urandom), $urandom);
    end
    stray_en = 0;
    txn(0, 16'hFFFC, 2'b00, 0);
    txn(0, 16'hFFFF, 2'b01, 0);
    txn(0, 16'h00FC, 2'b00, 0);

    repeat (10) @(negedge clk);
    chk("exp_rsp_drained", exp_rsp.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);
    chk("exp_wr_drained", exp_wr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
